// File: rtl/hc595_rx.sv
// hc595_rx: oversampling receiver for a 74HC595-style 3-wire serial stream.
// The three pins are synchronised to i_sys_clk. Rising edges of sh_cp shift
// ds into a shadow register. Rising edges of st_cp present that register on
// a parallel bus and flag frames whose bit count differs from WIDTH. A shift
// that stalls for TIMEOUT_CYC cycles is abandoned without producing a word.
module hc595_rx #(
    parameter int WIDTH       = 14,    // frame length in bits
    parameter int TIMEOUT_CYC = 1000,  // idle cycles before a partial frame is dropped (>= 2)
    parameter int CNT_W       = 8      // bit counter width, 2**CNT_W > WIDTH
) (
    input  logic             i_sys_clk,
    input  logic             i_reset,
    input  logic             i_sh_cp,
    input  logic             i_st_cp,
    input  logic             i_ds,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_data_valid,
    output logic             o_frame_err,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic             o_busy
);

    // Timeout counter only has to reach TIMEOUT_CYC-1.
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(WIDTH);
    localparam logic [TO_W-1:0]  TO_ZERO   = '0;
    localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    // Bit positions of the pins inside the synchroniser vectors.
    localparam int PIN_SH = 0;
    localparam int PIN_ST = 1;
    localparam int PIN_DS = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    genvar gi;

    // ------------------------------------------------------------------
    // Pin synchronisation and edge detection
    // ------------------------------------------------------------------
    logic [2:0] w_pins;
    logic [2:0] w_sync;
    logic [1:0] w_hist;

    assign w_pins = {i_ds, i_st_cp, i_sh_cp};

    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic r_meta;
            logic r_stable;

            // Two-flop synchroniser for one asynchronous pin.
            always_ff @(posedge i_sys_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_meta   <= 1'b0;
                    r_stable <= 1'b0;
                end else begin
                    r_meta   <= w_pins[gi];
                    r_stable <= r_meta;
                end
            end

            assign w_sync[gi] = r_stable;
        end
    endgenerate

    // Only the two clock pins need a history flop; ds is consumed at its
    // stage-2 value, which lines it up with the sh_cp edge detected there.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_hist
            logic r_prev;

            // History flop: previous synchronised level for rising-edge detect.
            always_ff @(posedge i_sys_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= w_sync[gi];
                end
            end

            assign w_hist[gi] = r_prev;
        end
    endgenerate

    logic w_sh_rise;
    logic w_st_rise;
    logic w_ds;

    assign w_sh_rise = w_sync[PIN_SH] & ~w_hist[PIN_SH];
    assign w_st_rise = w_sync[PIN_ST] & ~w_hist[PIN_ST];
    assign w_ds      = w_sync[PIN_DS];

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_frame_err;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_busy;
    logic [TO_W-1:0]  r_to_cnt;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_shreg_next;
    logic [WIDTH-1:0] w_data_out_next;
    logic             w_data_valid_next;
    logic             w_frame_err_next;
    logic [CNT_W-1:0] w_bit_cnt_next;
    logic             w_busy_next;
    logic [TO_W-1:0]  w_to_cnt_next;

    // Saturating increment: a runaway stream parks at the maximum count.
    logic [CNT_W-1:0] w_bit_cnt_inc;
    assign w_bit_cnt_inc = (r_bit_cnt == CNT_MAX) ? r_bit_cnt : (r_bit_cnt + CNT_ONE);

    // FSM state register.
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath decode from the detected pin edges.
    always_comb begin
        w_state_next      = r_state;
        w_shreg_next      = r_shreg;
        w_data_out_next   = r_data_out;
        w_data_valid_next = 1'b0;
        w_frame_err_next  = r_frame_err;
        w_bit_cnt_next    = r_bit_cnt;
        w_to_cnt_next     = r_to_cnt;

        // The latch always sees the shift register as it was before any
        // shift in the same cycle, and judges the count before increment.
        if (w_st_rise) begin
            w_data_out_next   = r_shreg;
            w_data_valid_next = 1'b1;
            w_frame_err_next  = (r_bit_cnt != CNT_FRAME);
        end

        // The shift register is never cleared by a latch, like a real 595.
        if (w_sh_rise) begin
            w_shreg_next = {r_shreg[WIDTH-2:0], w_ds};
        end

        case (r_state)
            ST_IDLE: begin
                w_to_cnt_next = TO_ZERO;
                if (w_sh_rise) begin
                    w_bit_cnt_next = CNT_ONE;
                    w_state_next   = ST_SHIFT;
                end else begin
                    w_bit_cnt_next = CNT_ZERO;
                end
            end

            ST_SHIFT: begin
                if (w_sh_rise) begin
                    // A coincident latch closes the old frame; this bit opens the next.
                    w_bit_cnt_next = w_st_rise ? CNT_ONE : w_bit_cnt_inc;
                    w_to_cnt_next  = TO_ZERO;
                end else if (w_st_rise) begin
                    w_bit_cnt_next = CNT_ZERO;
                    w_to_cnt_next  = TO_ZERO;
                    w_state_next   = ST_IDLE;
                end else if (r_to_cnt == TO_LAST) begin
                    // Stalled frame: drop the count silently, keep shreg and data_out.
                    w_bit_cnt_next = CNT_ZERO;
                    w_to_cnt_next  = TO_ZERO;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_to_cnt_next = r_to_cnt + TO_ONE;
                end
            end

            default: begin
                w_bit_cnt_next = CNT_ZERO;
                w_to_cnt_next  = TO_ZERO;
                w_state_next   = ST_IDLE;
            end
        endcase

        w_busy_next = (w_bit_cnt_next != CNT_ZERO);
    end

    // Datapath and output registers; nothing reaches the outputs unregistered.
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shreg      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_bit_cnt    <= '0;
            r_busy       <= 1'b0;
            r_to_cnt     <= '0;
        end else begin
            r_shreg      <= w_shreg_next;
            r_data_out   <= w_data_out_next;
            r_data_valid <= w_data_valid_next;
            r_frame_err  <= w_frame_err_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_busy       <= w_busy_next;
            r_to_cnt     <= w_to_cnt_next;
        end
    end

    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;
    assign o_frame_err  = r_frame_err;
    assign o_bit_cnt    = r_bit_cnt;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_hc595_rx.sv
// tb_hc595_rx: directed stimulus for hc595_rx. A frame-level model tracks
// what the receiver must present (edges act two clocks after the pin change)
// and is compared with the DUT every cycle; literal checks pin the model.
module tb_hc595_rx;

    localparam int WIDTH       = 14;
    localparam int TIMEOUT_CYC = 1000;
    localparam int CNT_W       = 8;
    localparam int CNT_SAT     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sh  = 1'b0;
    logic             st  = 1'b0;
    logic             ds  = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             frame_err;
    logic [CNT_W-1:0] bit_cnt;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int vcount   = 0;
    int last_vcyc = -1;
    int rise_cyc;
    int v0;

    hc595_rx #(
        .WIDTH      (WIDTH),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .i_sys_clk   (clk),
        .i_reset     (rst),
        .i_sh_cp     (sh),
        .i_st_cp     (st),
        .i_ds        (ds),
        .o_data_out  (data_out),
        .o_data_valid(data_valid),
        .o_frame_err (frame_err),
        .o_bit_cnt   (bit_cnt),
        .o_busy      (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- frame-level model ----------------
    // Pins sampled at each edge; an edge seen at sample k is acted on two
    // edges later.
    logic [2:0]       pin_d1, pin_d2, pin_d3;  // {ds, st, sh}
    logic [WIDTH-1:0] m_shreg, m_data;
    logic             m_valid, m_ferr;
    int               m_cnt, m_idle;
    logic             e_sh, e_st, e_d;

    initial begin
        pin_d1 = '0; pin_d2 = '0; pin_d3 = '0;
        m_shreg = '0; m_data = '0; m_valid = 1'b0; m_ferr = 1'b0;
        m_cnt = 0; m_idle = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                pin_d1 = '0; pin_d2 = '0; pin_d3 = '0;
                m_shreg = '0; m_data = '0; m_valid = 1'b0; m_ferr = 1'b0;
                m_cnt = 0; m_idle = 0;
            end else begin
                e_sh = pin_d2[0] && !pin_d3[0];
                e_st = pin_d2[1] && !pin_d3[1];
                e_d  = pin_d2[2];
                pin_d3 = pin_d2;
                pin_d2 = pin_d1;
                pin_d1 = {ds, st, sh};
                m_valid = 1'b0;
                if (e_st) begin
                    m_data  = m_shreg;
                    m_valid = 1'b1;
                    m_ferr  = (m_cnt != WIDTH);
                end
                if (e_sh) begin
                    m_shreg = {m_shreg[WIDTH-2:0], e_d};
                    m_cnt   = e_st ? 1 : ((m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT);
                    m_idle  = 0;
                end else if (e_st) begin
                    m_cnt  = 0;
                    m_idle = 0;
                end else if (m_cnt != 0) begin
                    m_idle = m_idle + 1;
                    if (m_idle >= TIMEOUT_CYC) begin
                        m_cnt  = 0;
                        m_idle = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [WIDTH+CNT_W+2:0] exp_vec, act_vec;

    initial begin
        forever begin
            @(negedge clk);
            exp_vec = {m_data, m_valid, m_ferr, CNT_W'(m_cnt), (m_cnt != 0)};
            act_vec = {data_out, data_valid, frame_err, bit_cnt, busy};
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL cycle_outputs @cyc %0d: got {data,valid,ferr,cnt,busy}=0x%0h, expected 0x%0h",
                         cyc, act_vec, exp_vec);
            end
            if (data_valid === 1'b1) begin
                vcount++;
                last_vcyc = cyc;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 8-cycle sh_cp period, 50% duty; ds changes while sh_cp falls.
    task automatic shift_bit(input logic b);
        sh = 1'b0;
        ds = b;
        wait_cyc(4);
        sh = 1'b1;
        wait_cyc(4);
    endtask

    task automatic shift_word(input logic [WIDTH-1:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic latch();
        sh = 1'b0;
        wait_cyc(4);
        st       = 1'b1;
        rise_cyc = cyc;
        v0       = vcount;
        wait_cyc(4);
        st = 1'b0;
        wait_cyc(4);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(50);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_valid", 32'(data_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_bit_cnt", 32'(bit_cnt), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        // Clean frame.
        shift_word(14'h2A5C, 14);
        check("f1_bit_cnt_before_latch", 32'(bit_cnt), 32'd14);
        check("f1_busy_before_latch", 32'(busy), 32'h1);
        latch();
        check("f1_data_out", 32'(data_out), 32'h2A5C);
        check("f1_frame_err", 32'(frame_err), 32'h0);
        check("f1_bit_cnt", 32'(bit_cnt), 32'h0);
        check("f1_busy", 32'(busy), 32'h0);
        check("f1_valid_pulses", 32'(vcount - v0), 32'd1);
        check("f1_valid_latency", 32'(last_vcyc - rise_cyc), 32'd3);

        // Short frame: old low bits shift up.
        shift_word(14'h03FF, 10);
        latch();
        check("f2_data_out", 32'(data_out), 32'h33FF);
        check("f2_frame_err", 32'(frame_err), 32'h1);
        check("f2_valid_pulses", 32'(vcount - v0), 32'd1);

        // Clean frame clears the error.
        shift_word(14'h0001, 14);
        latch();
        check("f3_data_out", 32'(data_out), 32'h0001);
        check("f3_frame_err", 32'(frame_err), 32'h0);

        // 14 bits then a 15th sh_cp rise coincident with st_cp rise.
        shift_word(14'h1234, 14);
        sh = 1'b0;
        ds = 1'b1;
        wait_cyc(4);
        sh       = 1'b1;
        st       = 1'b1;
        rise_cyc = cyc;
        v0       = vcount;
        wait_cyc(4);
        sh = 1'b0;
        st = 1'b0;
        wait_cyc(4);
        check("sim_data_out", 32'(data_out), 32'h1234);
        check("sim_frame_err", 32'(frame_err), 32'h0);
        check("sim_bit_cnt", 32'(bit_cnt), 32'd1);
        check("sim_busy", 32'(busy), 32'h1);
        check("sim_valid_latency", 32'(last_vcyc - rise_cyc), 32'd3);

        // Partial frame then stall: timeout drops the count silently.
        shift_word(14'h0016, 5);
        sh = 1'b0;
        check("to_bit_cnt_after_shift", 32'(bit_cnt), 32'd6);
        v0 = vcount;
        wait_cyc(TIMEOUT_CYC - 10);
        check("to_bit_cnt_before_expiry", 32'(bit_cnt), 32'd6);
        wait_cyc(15);
        check("to_bit_cnt", 32'(bit_cnt), 32'h0);
        check("to_busy", 32'(busy), 32'h0);
        check("to_no_valid", 32'(vcount - v0), 32'd0);
        check("to_data_out", 32'(data_out), 32'h1234);

        // Reset mid-frame, effective without a clock edge.
        shift_word(14'h007F, 7);
        sh = 1'b0;
        wait_cyc(4);
        check("pre_reset_bit_cnt", 32'(bit_cnt), 32'd7);
        #3 rst = 1'b1;
        #1;
        check("async_rst_data_out", 32'(data_out), 32'h0);
        check("async_rst_valid", 32'(data_valid), 32'h0);
        check("async_rst_frame_err", 32'(frame_err), 32'h0);
        check("async_rst_bit_cnt", 32'(bit_cnt), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        wait_cyc(1);
        #3 rst = 1'b0;

        shift_word(14'h1555, 14);
        latch();
        check("f5_data_out", 32'(data_out), 32'h1555);
        check("f5_frame_err", 32'(frame_err), 32'h0);
        check("f5_valid_pulses", 32'(vcount - v0), 32'd1);

        wait_cyc(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
